// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu_pkg: shared FSM state encodings and RV32I funct3 constants.
// Also provides the `XLEN default used by every LSU file.
`ifndef XLEN
`define XLEN 32
`endif

package riscv_lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic logic f3_legal(input logic [2:0] f3);
    return !((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111));
  endfunction

endpackage

// File: rtl/riscv_lsu_ldext.sv
// riscv_lsu_ldext: selects the load byte/half from the bus word
// and sign- or zero-extends it according to funct3.
`ifndef XLEN
`define XLEN 32
`endif

module riscv_lsu_ldext
  import riscv_lsu_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        off,
  input  logic [`XLEN-1:0]  word,
  output logic [`XLEN-1:0]  data
);

  logic [7:0]  b;
  logic [15:0] h;

  // lane select, then extension; halfwords only look at off[1]
  always_comb begin
    b    = word[7:0];
    h    = off[1] ? word[31:16] : word[15:0];
    data = word;
    case (off)
      2'd0: b = word[7:0];
      2'd1: b = word[15:8];
      2'd2: b = word[23:16];
      2'd3: b = word[31:24];
      default: b = word[7:0];
    endcase
    case (funct3)
      F3_LB:   data = {{(`XLEN-8){b[7]}}, b};
      F3_LBU:  data = {{(`XLEN-8){1'b0}}, b};
      F3_LH:   data = {{(`XLEN-16){h[15]}}, h};
      F3_LHU:  data = {{(`XLEN-16){1'b0}}, h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: RV32I load/store unit, one outstanding bus access.
// Define RISCV_LSU_MISALIGN_TRAP_EN to trap misaligned half/word.
`ifndef XLEN
`define XLEN 32
`endif

module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_lsu_req,
  input  logic              i_lsu_wen,
  input  logic [2:0]        i_lsu_funct3,
  input  logic [`XLEN-1:0]  i_lsu_addr,
  input  logic [`XLEN-1:0]  i_lsu_wr_data,
  output logic [`XLEN-1:0]  o_lsu_rd_data,
  output logic              o_lsu_stall,
  output logic              o_lsu_done,
  output logic              o_lsu_err,
  output logic              o_mem_req,
  output logic              o_mem_wen,
  output logic [`XLEN-1:0]  o_mem_addr,
  output logic [3:0]        o_mem_be,
  output logic [`XLEN-1:0]  o_mem_wr_data,
  input  logic              i_mem_ack,
  input  logic [`XLEN-1:0]  i_mem_rd_data
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  lsu_state_t       state;
  logic [CW-1:0]    cnt;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic             legal;
  logic             misalign;
  logic             tmo;
  logic [3:0]       be_n;
  logic [`XLEN-1:0] wd_n;
  logic [`XLEN-1:0] ext;

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
  assign misalign =
    ((i_lsu_funct3[1:0] == 2'b01) && i_lsu_addr[0]) ||
    ((i_lsu_funct3[1:0] == 2'b10) && (i_lsu_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign legal = f3_legal(i_lsu_funct3) && !misalign;

  assign tmo = (TIMEOUT_CYCLES != 0) &&
               (cnt == CW'(TIMEOUT_CYCLES - 1));

  assign o_lsu_stall = (state == S_BUS) ||
                       ((state == S_IDLE) && i_lsu_req);

  // store byte enables and lane replication; loads use the full word
  always_comb begin
    be_n = 4'b1111;
    wd_n = i_lsu_wr_data;
    if (i_lsu_wen) begin
      case (i_lsu_funct3)
        F3_SB: begin
          be_n = 4'b0001 << i_lsu_addr[1:0];
          wd_n = {(`XLEN/8){i_lsu_wr_data[7:0]}};
        end
        F3_SH: begin
          be_n = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
          wd_n = {(`XLEN/16){i_lsu_wr_data[15:0]}};
        end
        default: begin
          be_n = 4'b1111;
          wd_n = i_lsu_wr_data;
        end
      endcase
    end
  end

  riscv_lsu_ldext u_ldext (
    .funct3 (f3_q),
    .off    (off_q),
    .word   (i_mem_rd_data),
    .data   (ext)
  );

  // access FSM with registered bus and completion outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      f3_q          <= '0;
      off_q         <= '0;
      o_mem_req     <= 1'b0;
      o_mem_wen     <= 1'b0;
      o_mem_addr    <= '0;
      o_mem_be      <= '0;
      o_mem_wr_data <= '0;
      o_lsu_rd_data <= '0;
      o_lsu_done    <= 1'b0;
      o_lsu_err     <= 1'b0;
    end else begin
      o_lsu_done <= 1'b0;
      o_lsu_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_lsu_req) begin
            if (legal) begin
              state         <= S_BUS;
              cnt           <= '0;
              f3_q          <= i_lsu_funct3;
              off_q         <= i_lsu_addr[1:0];
              o_mem_req     <= 1'b1;
              o_mem_wen     <= i_lsu_wen;
              o_mem_addr    <= {i_lsu_addr[`XLEN-1:2], 2'b00};
              o_mem_be      <= be_n;
              o_mem_wr_data <= wd_n;
            end else begin
              state      <= S_RESP;
              o_lsu_done <= 1'b1;
              o_lsu_err  <= 1'b1;
            end
          end
        end
        S_BUS: begin
          if (i_mem_ack) begin
            state      <= S_RESP;
            o_mem_req  <= 1'b0;
            o_lsu_done <= 1'b1;
            if (!o_mem_wen) o_lsu_rd_data <= ext;
          end else if (tmo) begin
            state      <= S_RESP;
            o_mem_req  <= 1'b0;
            o_lsu_done <= 1'b1;
            o_lsu_err  <= 1'b1;
          end else if (TIMEOUT_CYCLES != 0) begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state     <= S_IDLE;
          o_mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed bench for riscv_lsu with TIMEOUT_CYCLES = 4.
// Completion responses are checked by a scoreboard monitor.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        wen;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rd_data;
  logic        stall;
  logic        done;
  logic        err;
  logic        mreq;
  logic        mwen;
  logic [31:0] maddr;
  logic [3:0]  mbe;
  logic [31:0] mwd;
  logic        ack;
  logic [31:0] mrd;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  riscv_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_lsu_req     (req),
    .i_lsu_wen     (wen),
    .i_lsu_funct3  (f3),
    .i_lsu_addr    (addr),
    .i_lsu_wr_data (wdata),
    .o_lsu_rd_data (rd_data),
    .o_lsu_stall   (stall),
    .o_lsu_done    (done),
    .o_lsu_err     (err),
    .o_mem_req     (mreq),
    .o_mem_wen     (mwen),
    .o_mem_addr    (maddr),
    .o_mem_be      (mbe),
    .o_mem_wr_data (mwd),
    .i_mem_ack     (ack),
    .i_mem_rd_data (mrd)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitor: every done pulse must match the oldest entry
  always @(negedge clk) begin
    if (err && !done) chk("err_without_done", {31'b0, done}, 32'd1);
    if (done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 want none (cycle %0d)",
                 cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("done_err", {31'b0, err}, {31'b0, mon_e.err});
        chk("rd_data", rd_data, mon_e.rd);
        chk("latency", cyc, mon_e.at);
      end
    end
  end

  task automatic access(
    input logic        a_wen,
    input logic [2:0]  a_f3,
    input logic [31:0] a_addr,
    input logic [31:0] a_wd,
    input int          ack_at,
    input logic [31:0] rword,
    input logic        e_bus,
    input logic [31:0] e_addr,
    input logic [3:0]  e_be,
    input logic [31:0] e_wd,
    input logic        e_err,
    input logic [31:0] e_rd,
    input int          lat
  );
    int bus;
    bit fin;
    exp_t e;
    @(posedge clk); #1;
    req   = 1'b1;
    wen   = a_wen;
    f3    = a_f3;
    addr  = a_addr;
    wdata = a_wd;
    e.err = e_err;
    e.rd  = e_rd;
    e.at  = cyc + lat;
    sb.push_back(e);
    @(negedge clk);
    chk("stall_on_req", {31'b0, stall}, 32'd1);
    bus = 0;
    fin = 0;
    for (int c = 0; c < 40 && !fin; c++) begin
      if (done) begin
        fin = 1;
        chk("stall_in_resp", {31'b0, stall}, 32'd0);
        chk("mem_req_in_resp", {31'b0, mreq}, 32'd0);
      end else begin
        if (mreq) begin
          bus++;
          chk("stall_in_bus", {31'b0, stall}, 32'd1);
          if (bus == 1) begin
            chk("mem_addr", maddr, e_addr);
            chk("mem_be", {28'b0, mbe}, {28'b0, e_be});
            chk("mem_wr_data", mwd, e_wd);
            chk("mem_wen", {31'b0, mwen}, {31'b0, a_wen});
          end
          if (bus == ack_at) begin
            ack = 1'b1;
            mrd = rword;
          end
        end
        @(posedge clk); #1;
        ack = 1'b0;
        mrd = 32'h5A5A_5A5A;
        @(negedge clk);
      end
    end
    if (!fin) begin
      tests++;
      fails++;
      $display("FAIL done_wait: got no done within 40 cycles want done");
    end
    chk("bus_used", {31'b0, (bus != 0)}, {31'b0, e_bus});
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk("no_restart_from_resp", {31'b0, mreq}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    req   = 1'b0;
    wen   = 1'b0;
    f3    = 3'b000;
    addr  = '0;
    wdata = '0;
    ack   = 1'b0;
    mrd   = 32'h5A5A_5A5A;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", {31'b0, mreq}, 32'd0);
    chk("rst_mem_be", {28'b0, mbe}, 32'd0);
    chk("rst_mem_addr", maddr, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_done_err", {30'b0, done, err}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // LW 0x100, ack in first BUS cycle
    access(0, 3'b010, 32'h100, 32'h0, 1, 32'hDEAD_BEEF,
           1, 32'h100, 4'b1111, 32'h0, 0, 32'hDEAD_BEEF, 2);
    // LB / LBU at 0x103 from lane 3 (0x80)
    access(0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF_FF7F,
           1, 32'h100, 4'b1111, 32'h0, 0, 32'hFFFF_FF80, 2);
    access(0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF_FF7F,
           1, 32'h100, 4'b1111, 32'h0, 0, 32'h0000_0080, 2);
    // LH upper half, ack in third BUS cycle
    access(0, 3'b001, 32'h102, 32'h0, 3, 32'h80FF_FF7F,
           1, 32'h100, 4'b1111, 32'h0, 0, 32'hFFFF_80FF, 4);
    // LHU lower half
    access(0, 3'b101, 32'h100, 32'h0, 1, 32'h80FF_FF7F,
           1, 32'h100, 4'b1111, 32'h0, 0, 32'h0000_FF7F, 2);
    // SH 0x202: upper lanes, rd_data untouched
    access(1, 3'b001, 32'h202, 32'h0000_ABCD, 2, 32'h0,
           1, 32'h200, 4'b1100, 32'hABCD_ABCD, 0, 32'h0000_FF7F, 3);
    // SB 0x201: lane 1
    access(1, 3'b000, 32'h201, 32'h1234_5678, 1, 32'h0,
           1, 32'h200, 4'b0010, 32'h7878_7878, 0, 32'h0000_FF7F, 2);
    // SW 0x300
    access(1, 3'b010, 32'h300, 32'hCAFE_F00D, 1, 32'h0,
           1, 32'h300, 4'b1111, 32'hCAFE_F00D, 0, 32'h0000_FF7F, 2);
    // timeout: no ack for 4 BUS cycles
    access(0, 3'b010, 32'h400, 32'h0, 0, 32'h0,
           1, 32'h400, 4'b1111, 32'h0, 1, 32'h0000_FF7F, 5);
    // ack on the timeout cycle wins
    access(0, 3'b010, 32'h404, 32'h0, 4, 32'h0123_4567,
           1, 32'h404, 4'b1111, 32'h0, 0, 32'h0123_4567, 5);
    // unsupported funct3: immediate error, no bus
    access(0, 3'b011, 32'h500, 32'h0, 1, 32'h0,
           0, 32'h0, 4'b0, 32'h0, 1, 32'h0123_4567, 1);
    access(1, 3'b110, 32'h504, 32'h0, 1, 32'h0,
           0, 32'h0, 4'b0, 32'h0, 1, 32'h0123_4567, 1);
    // misaligned LW 0x102
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    access(0, 3'b010, 32'h102, 32'h0, 1, 32'h89AB_CDEF,
           0, 32'h0, 4'b0, 32'h0, 1, 32'h0123_4567, 1);
`else
    access(0, 3'b010, 32'h102, 32'h0, 1, 32'h89AB_CDEF,
           1, 32'h100, 4'b1111, 32'h0, 0, 32'h89AB_CDEF, 2);
`endif

    // reset in the second BUS cycle, then a late ack
    @(posedge clk); #1;
    req  = 1'b1;
    wen  = 1'b0;
    f3   = 3'b010;
    addr = 32'h500;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstbus_mem_req", {31'b0, mreq}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    ack = 1'b1;
    mrd = 32'h1111_1111;
    @(negedge clk);
    chk("rstbus_mem_req_0", {31'b0, mreq}, 32'd0);
    chk("rstbus_mem_addr_0", maddr, 32'd0);
    chk("rstbus_mem_be_0", {28'b0, mbe}, 32'd0);
    chk("rstbus_rd_data_0", rd_data, 32'd0);
    chk("rstbus_done_err_0", {30'b0, done, err}, 32'd0);
    @(posedge clk); #1;
    ack = 1'b0;
    mrd = 32'h5A5A_5A5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstbus_no_done", {31'b0, done}, 32'd0);
      chk("late_ack_ignored", rd_data, 32'd0);
    end
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
